// File: rtl/fu_mem_param.sv
`default_nettype none
// ============================================================================
//  Module      : fu_mem_param
//  Description : Load/store functional unit. It serves one memory op at a
//                time. It registers operands on EN, computes rs1+imm, and
//                accesses an internal word-organised RAM with byte, half and
//                word granularity and sign/zero extension. It raises a
//                one-cycle finish pulse LAT edges after acceptance.
//                Optional macro MEM_MISALIGN_TRAP_EN adds the misalign output
//                and suppresses misaligned accesses. Without the macro,
//                misaligned accesses are force-aligned.
//  Revision    : 1.0 - initial release
// ============================================================================
module fu_mem_param #(
    parameter int LAT   = 2,
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EN,
    input  logic        mem_w,
    input  logic [2:0]  bhw,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    output logic [31:0] mem_data,
    output logic        finish,
    output logic        busy
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    localparam int         AW         = $clog2(DEPTH);
    // Every latency, LAT=1 included, goes through WAIT with a preset of
    // LAT-1. As a result, finish appears exactly LAT edges after acceptance.
    localparam logic [3:0] c_LAT_INIT = 4'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_finish;
    logic        r_misalign;
    logic [31:0] r_mem_data;
    logic        r_mem_w;
    logic [2:0]  r_bhw;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [31:0] r_imm;
    logic [31:0] r_ram [DEPTH];

    logic [31:0]   w_addr;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_word;
    logic [31:0]   w_shift;
    logic [15:0]   w_half;
    logic          w_is_h;
    logic          w_is_w;
    logic          w_misal;
    logic          w_trap;
    logic          w_accept;
    logic          w_commit;
    logic          w_do_store;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_load;
    logic          w_unused;

    assign w_addr   = r_rs1 + r_imm;
    assign w_idx    = w_addr[AW+1:2];
    assign w_word   = r_ram[w_idx];
    assign w_shift  = w_word >> {w_addr[1:0], 3'b000};
    assign w_half   = w_addr[1] ? w_word[31:16] : w_word[15:0];
    assign w_is_h   = (r_bhw == 3'b001) || (r_bhw == 3'b101);
    assign w_is_w   = (r_bhw == 3'b010);
    assign w_misal  = (w_is_h & w_addr[0]) | (w_is_w & (w_addr[1:0] != 2'b00));
    assign w_accept = EN && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_trap   = w_misal;
    assign misalign = r_misalign;
    assign w_unused = ^{w_addr[31:AW+2]};
`else
    // Without the trap, H uses only addr[1] and W ignores addr[1:0].
    // This force-aligns misaligned accesses.
    assign w_trap   = 1'b0;
    assign w_unused = ^{w_addr[31:AW+2], w_misal, r_misalign};
`endif

    assign w_do_store = w_commit && r_mem_w && (w_be != 4'b0000) && !w_trap;

    // Store lane selection and data replication into the addressed lanes.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'd0;
        case (r_bhw)
            3'b000, 3'b100: begin
                w_be    = 4'b0001 << w_addr[1:0];
                w_wdata = {4{r_rs2[7:0]}};
            end
            3'b001, 3'b101: begin
                w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_rs2[15:0]}};
            end
            3'b010: begin
                w_be    = 4'b1111;
                w_wdata = r_rs2;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = 32'd0;
            end
        endcase
    end

    // Load data extraction with sign/zero extension. An illegal or trapped
    // access reads as zero.
    always_comb begin
        w_load = 32'd0;
        case (r_bhw)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            3'b010:  w_load = w_word;
            default: w_load = 32'd0;
        endcase
        if (w_trap) begin
            w_load = 32'd0;
        end
    end

    // RAM byte-lane write on the edge that enters DONE. The RAM is not reset.
    always_ff @(posedge clk) begin
        if (w_do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_ram[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // Control FSM: accept in IDLE/DONE, count down in WAIT, pulse finish in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_busy     <= 1'b0;
            r_finish   <= 1'b0;
            r_misalign <= 1'b0;
            r_mem_data <= 32'd0;
            r_mem_w    <= 1'b0;
            r_bhw      <= 3'd0;
            r_rs1      <= 32'd0;
            r_rs2      <= 32'd0;
            r_imm      <= 32'd0;
        end else begin
            r_finish   <= 1'b0;
            r_misalign <= 1'b0;
            if (w_accept) begin
                r_mem_w <= mem_w;
                r_bhw   <= bhw;
                r_rs1   <= rs1_data;
                r_rs2   <= rs2_data;
                r_imm   <= imm;
                r_cnt   <= c_LAT_INIT;
                r_busy  <= 1'b1;
                r_state <= S_WAIT;
            end else begin
                case (r_state)
                    S_WAIT: begin
                        if (r_cnt == 4'd0) begin
                            r_state    <= S_DONE;
                            r_busy     <= 1'b0;
                            r_finish   <= 1'b1;
                            r_misalign <= w_trap;
                            if (!r_mem_w) begin
                                r_mem_data <= w_load;
                            end
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign mem_data = r_mem_data;
    assign finish   = r_finish;
    assign busy     = r_busy;

endmodule
`default_nettype wire
